// File: rtl/ble_mod_pkg.sv
// Shared definitions for the GFSK symbol modulator: FSM state encoding and
// default frequency-control word geometry.
package ble_mod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FCW_W_DEF   = 12;
    localparam int DEV_FCW_DEF = 256;

endpackage

// File: rtl/fcw_slew.sv
// Clamped step limiter: moves cur toward target by at most DEV_STEP, landing
// exactly on target when it is within one step.
module fcw_slew #(
    parameter int FCW_W    = 12,
    parameter int DEV_STEP = 64
) (
    input  logic signed [FCW_W-1:0] target,
    input  logic signed [FCW_W-1:0] cur,
    output logic signed [FCW_W-1:0] nxt
);

    localparam logic signed [FCW_W:0] STEP = (FCW_W+1)'(DEV_STEP);

    logic signed [FCW_W:0] diff_s;

    // One extra bit keeps a full +DEV to -DEV swing from wrapping.
    always_comb begin
        diff_s = {target[FCW_W-1], target} - {cur[FCW_W-1], cur};
        if (diff_s > STEP) begin
            nxt = cur + STEP[FCW_W-1:0];
        end else if (diff_s < -STEP) begin
            nxt = cur - STEP[FCW_W-1:0];
        end else begin
            nxt = target;
        end
    end

endmodule

// File: rtl/gfsk_symbol_mod.sv
// GFSK symbol modulator: holds each symbol for SAMPLES_PER_SYM clocks and emits
// a signed FCW of +/-DEV_FCW. Define BLE_MOD_RAMP_EN to slew fcw by DEV_STEP per clock.
module gfsk_symbol_mod
    import ble_mod_pkg::*;
#(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int FCW_W           = FCW_W_DEF,
    parameter int DEV_FCW         = DEV_FCW_DEF
`ifdef BLE_MOD_RAMP_EN
    ,
    parameter int DEV_STEP        = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    symVal,
    output logic                    symDone,
    output logic signed [FCW_W-1:0] fcw,
    output logic                    txActive
);

    localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLES_PER_SYM - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SAMPLES_PER_SYM - 2);
    localparam logic signed [FCW_W-1:0] FCW_ZERO = {FCW_W{1'b0}};
    localparam logic signed [FCW_W-1:0] FCW_POS  = FCW_W'(DEV_FCW);
    localparam logic signed [FCW_W-1:0] FCW_NEG  = FCW_W'(-DEV_FCW);

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_nxt_s;
    logic                      sym_q_r;
    logic                      done_r;
    logic                      active_r;
    logic signed [FCW_W-1:0]   fcw_r;
    logic signed [FCW_W-1:0]   fcw_nxt_s;
    logic signed [FCW_W-1:0]   dest_s;
    logic signed [FCW_W-1:0]   slew_s;

`ifdef BLE_MOD_RAMP_EN
    fcw_slew #(
        .FCW_W    (FCW_W),
        .DEV_STEP (DEV_STEP)
    ) u_fcw_slew (
        .target (dest_s),
        .cur    (fcw_r),
        .nxt    (slew_s)
    );
`else
    assign slew_s = dest_s;
`endif

    // Destination of fcw and its next value; fcw holds during cnt==0 while the new symbol is captured.
    always_comb begin
        dest_s    = sym_q_r ? FCW_POS : FCW_NEG;
        fcw_nxt_s = FCW_ZERO;
        case (state_r)
            IDLE: begin
                fcw_nxt_s = FCW_ZERO;
            end
            RUN: begin
                if (cnt_r != CNT_ZERO) begin
                    fcw_nxt_s = slew_s;
                end else begin
                    fcw_nxt_s = fcw_r;
                end
            end
            DRAIN: begin
                dest_s    = FCW_ZERO;
                fcw_nxt_s = slew_s;
            end
            default: begin
                fcw_nxt_s = FCW_ZERO;
            end
        endcase
    end

    // Next-state and symbol counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_MAX) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (start) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                cnt_nxt_s = CNT_ZERO;
                if (fcw_nxt_s == FCW_ZERO) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter, symbol capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            sym_q_r  <= 1'b0;
            fcw_r    <= FCW_ZERO;
            done_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            fcw_r    <= fcw_nxt_s;
            if (state_r == RUN && cnt_r == CNT_ZERO) begin
                sym_q_r <= symVal;
            end
            // Raised one edge early so the pulse lines up with the cnt==SAMPLES_PER_SYM-1 cycle.
            done_r   <= (state_r == RUN) && (cnt_r == CNT_PRE);
            active_r <= (state_nxt_s != IDLE);
        end
    end

    assign symDone  = done_r;
    assign fcw      = fcw_r;
    assign txActive = active_r;

endmodule

// File: tb/tb_gfsk_symbol_mod.sv
// Directed bench for gfsk_symbol_mod with default parameters (SPS=16, DEV=256).
// Set BLE_MOD_RAMP_EN to exercise the slewed build instead.
module tb_gfsk_symbol_mod;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               symVal;
    logic               symDone;
    logic signed [11:0] fcw;
    logic               txActive;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        logic start;
        logic sym;
        int   fcw;
        logic done;
        logic act;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    gfsk_symbol_mod dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .symVal   (symVal),
        .symDone  (symDone),
        .fcw      (fcw),
        .txActive (txActive)
    );

    task automatic add(input logic r, input logic s, input logic v,
                       input int f, input logic d, input logic a);
        vec_t t;
        t.rst = r; t.start = s; t.sym = v; t.fcw = f; t.done = d; t.act = a;
        vecs.push_back(t);
    endtask

    // Drive inputs, take one edge, sample 1 ns later and compare.
    task automatic step_check(input string name, input logic r, input logic s, input logic v,
                              input int f, input logic d, input logic a);
        logic signed [11:0] exp_f;
        exp_f  = 12'(f);
        rst    = r;
        start  = s;
        symVal = v;
        @(posedge clk);
        #1;
        checks++;
        if (fcw !== exp_f || symDone !== d || txActive !== a) begin
            errors++;
            $display("FAIL %s: got fcw=%0d symDone=%b txActive=%b, expected fcw=%0d symDone=%b txActive=%b",
                     name, fcw, symDone, txActive, exp_f, d, a);
        end
    endtask

    initial begin
        int  f;
        int  idx;
        logic d;
        logic [2:0] bits;

        rst    = 1'b1;
        start  = 1'b1;
        symVal = 1'b0;

        // Reset held with start high: everything stays quiet.
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);

`ifndef BLE_MOD_RAMP_EN
        // Bits 1,0,1 (bit k in position k); start drops at the edge ending the third symbol.
        bits = 3'b101;
        for (int n = 0; n <= 51; n++) begin
            idx = (n >= 1) ? (n - 1) / 16 : 0;
            if (idx > 2) idx = 2;
            if (n < 2)        f = 0;
            else if (n <= 17) f = 256;
            else if (n <= 33) f = -256;
            else if (n <= 48) f = 256;
            else              f = 0;
            d = (n == 15) || (n == 31) || (n == 47);
            add(1'b0, (n <= 47) ? 1'b1 : 1'b0, bits[idx], f, d, (n <= 48) ? 1'b1 : 1'b0);
        end
`else
        // Symbol 1 then 0: ramp up by 64, hold, then reverse over 8 clocks.
        for (int n = 0; n <= 27; n++) begin
            if (n < 2)        f = 0;
            else if (n <= 5)  f = 64 * (n - 1);
            else if (n <= 17) f = 256;
            else if (n <= 25) f = 256 - 64 * (n - 17);
            else              f = -256;
            d = (n == 15);
            add(1'b0, 1'b1, (n <= 16) ? 1'b1 : 1'b0, f, d, 1'b1);
        end
`endif

        foreach (vecs[i]) begin
            step_check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].start, vecs[i].sym,
                       vecs[i].fcw, vecs[i].done, vecs[i].act);
        end

`ifndef BLE_MOD_RAMP_EN
        // Start drops at cnt=5; the symbol still completes, then one DRAIN cycle.
        step_check("t4_enter", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        for (int n = 1; n <= 5; n++)
            step_check($sformatf("t4_run%0d", n), 1'b0, 1'b1, 1'b0, (n >= 2) ? -256 : 0, 1'b0, 1'b1);
        for (int n = 6; n <= 14; n++)
            step_check($sformatf("t4_tail%0d", n), 1'b0, 1'b0, 1'b0, -256, 1'b0, 1'b1);
        step_check("t4_done", 1'b0, 1'b0, 1'b0, -256, 1'b1, 1'b1);
        step_check("t4_drain", 1'b0, 1'b0, 1'b0, -256, 1'b0, 1'b1);
        // Start re-asserted in DRAIN is ignored; RUN only one clock after IDLE.
        step_check("t6_drain_start", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step_check("t6_rerun", 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        step_check("t5_cnt0", 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        for (int n = 2; n <= 7; n++)
            step_check($sformatf("t5_run%0d", n), 1'b0, 1'b1, 1'b1, 256, 1'b0, 1'b1);
        // Reset mid-packet aborts at that edge; RUN resumes the edge after.
        step_check("t5_rst", 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step_check("t5_resume", 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        step_check("t5_resume_cnt0", 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
